// File: rtl/alu_writeback.sv
// ALU writeback stage: one-cycle pending stage, architectural register file, and a
// result FIFO whose free space gates issue so no accepted result can be dropped.
module alu_writeback #(
   parameter int DEPTH = 4,
   parameter int NREGS = 8,
   localparam int RW = $clog2(NREGS),
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               issue_valid,
   input  logic [3:0]         issue_opcode,
   input  logic [RW-1:0]      issue_dest,
   output logic               issue_ready,
   input  logic signed [15:0] alu_out,
   input  logic [RW-1:0]      rd_addr,
   output logic [15:0]        rd_data,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [15:0]        res_data,
   output logic [RW-1:0]      res_dest,
   output logic               res_zero,
   output logic               res_neg,
   output logic [CW-1:0]      fifo_count,
   output logic               illegal_err
);

   logic [15:0]   regs [NREGS];
   logic [15:0]   fifo_data [DEPTH];
   logic [RW-1:0] fifo_dest [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          pend_valid;
   logic [RW-1:0] pend_dest;
   logic          pend_legal;
   logic          err;

   logic accept;
   logic push;
   logic pop;
   logic opcode_legal;

   // Pending result counts against free space so the slot is reserved at issue time.
   assign issue_ready  = ({1'b0, count} + (CW+1)'(pend_valid)) < (CW+1)'(DEPTH);
   assign accept       = issue_valid && issue_ready;
   assign opcode_legal = (issue_opcode >= 4'b1000) && (issue_opcode <= 4'b1101);
   assign push         = pend_valid && pend_legal;
   assign res_valid    = (count != '0);
   assign pop          = res_valid && res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_dest  <= '0;
         pend_legal <= 1'b0;
         err        <= 1'b0;
      end else begin
         pend_valid <= accept;
         if (accept) begin
            pend_dest  <= issue_dest;
            pend_legal <= opcode_legal;
         end
         if (pend_valid && !pend_legal) begin
            err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (push) begin
         regs[pend_dest] <= alu_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= alu_out;
         fifo_dest[wr_ptr] <= pend_dest;
      end
   end

   assign rd_data     = regs[rd_addr];
   assign res_data    = res_valid ? fifo_data[rd_ptr] : '0;
   assign res_dest    = res_valid ? fifo_dest[rd_ptr] : '0;
   assign res_zero    = res_valid && (fifo_data[rd_ptr] == 16'h0000);
   assign res_neg     = res_valid && fifo_data[rd_ptr][15];
   assign fifo_count  = count;
   assign illegal_err = err;

   no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a per-cycle vector table for the main flow,
// then hand sequences for illegal opcodes and reset behaviour.
module tb_alu_writeback;

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic [3:0]  issue_opcode;
   logic [2:0]  issue_dest;
   logic        issue_ready;
   logic signed [15:0] alu_out;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [2:0]  res_dest;
   logic        res_zero;
   logic        res_neg;
   logic [2:0]  fifo_count;
   logic        illegal_err;

   int tests;
   int fails;

   alu_writeback #(.DEPTH(4), .NREGS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_dest(issue_dest),
      .issue_ready(issue_ready), .alu_out(alu_out),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_dest(res_dest),
      .res_zero(res_zero), .res_neg(res_neg),
      .fifo_count(fifo_count), .illegal_err(illegal_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   typedef struct {
      logic        iv;
      logic [3:0]  op;
      logic [2:0]  dest;
      logic [15:0] alu;
      logic        rr;
      logic [2:0]  ra;
      logic        rdy;
      logic [2:0]  cnt;
      logic        rv;
      logic [15:0] rdata;
      logic [2:0]  rdest;
      logic        z;
      logic        n;
      logic [15:0] rd;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %h", name, act);
      end
   endtask

   function automatic logic [63:0] snap();
      return 64'({issue_ready, fifo_count, res_valid, res_data, res_dest,
                  res_zero, res_neg, rd_data, illegal_err});
   endfunction

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      issue_valid = 1'b0;
      issue_opcode = 4'h0;
      issue_dest = 3'd0;
      alu_out = 16'sh0;
      res_ready = 1'b0;
      rd_addr = 3'd0;

      //            iv  op     dst   alu        rr  ra    rdy cnt  rv  rdata     rdst  z  n  rd        err
      vecs.push_back('{1, 4'h8, 3'd3, 16'h0000, 0, 3'd3, 1, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h00F0, 0, 3'd3, 1, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 0, 3'd3, 1, 3'd1, 1, 16'h00F0, 3'd3, 0, 0, 16'h00F0, 0});
      vecs.push_back('{1, 4'h9, 3'd1, 16'h0000, 0, 3'd1, 1, 3'd1, 1, 16'h00F0, 3'd3, 0, 0, 16'h0000, 0});
      vecs.push_back('{1, 4'hA, 3'd2, 16'h1111, 0, 3'd1, 1, 3'd1, 1, 16'h00F0, 3'd3, 0, 0, 16'h0000, 0});
      vecs.push_back('{1, 4'hB, 3'd4, 16'h8000, 0, 3'd2, 1, 3'd2, 1, 16'h00F0, 3'd3, 0, 0, 16'h0000, 0});
      vecs.push_back('{1, 4'hC, 3'd5, 16'h0000, 0, 3'd4, 0, 3'd3, 1, 16'h00F0, 3'd3, 0, 0, 16'h0000, 0});
      vecs.push_back('{1, 4'hC, 3'd5, 16'hDEAD, 0, 3'd2, 0, 3'd4, 1, 16'h00F0, 3'd3, 0, 0, 16'h8000, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 1, 3'd4, 0, 3'd4, 1, 16'h00F0, 3'd3, 0, 0, 16'h0000, 0});
      vecs.push_back('{1, 4'hD, 3'd6, 16'h0000, 1, 3'd1, 1, 3'd3, 1, 16'h1111, 3'd1, 0, 0, 16'h1111, 0});
      vecs.push_back('{1, 4'h8, 3'd7, 16'h8001, 0, 3'd6, 1, 3'd2, 1, 16'h8000, 3'd2, 0, 1, 16'h0000, 0});
      vecs.push_back('{1, 4'h9, 3'd3, 16'h0000, 1, 3'd6, 0, 3'd3, 1, 16'h8000, 3'd2, 0, 1, 16'h8001, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 1, 3'd7, 1, 3'd3, 1, 16'h0000, 3'd4, 1, 0, 16'h0000, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 1, 3'd7, 1, 3'd2, 1, 16'h8001, 3'd6, 0, 1, 16'h0000, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 1, 3'd7, 1, 3'd1, 1, 16'h0000, 3'd7, 1, 0, 16'h0000, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 1, 3'd3, 1, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h00F0, 0});
      vecs.push_back('{1, 4'h8, 3'd3, 16'h0000, 0, 3'd3, 1, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h00F0, 0});
      vecs.push_back('{1, 4'h9, 3'd3, 16'h1234, 0, 3'd3, 1, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h00F0, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h5678, 1, 3'd3, 1, 3'd1, 1, 16'h1234, 3'd3, 0, 0, 16'h1234, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 1, 3'd3, 1, 3'd1, 1, 16'h5678, 3'd3, 0, 0, 16'h5678, 0});
      vecs.push_back('{0, 4'h0, 3'd0, 16'h0000, 0, 3'd3, 1, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h5678, 0});

      // Reset state
      repeat (2) @(negedge clk);
      #1 check("reset_state", snap(), 64'({1'b1, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0}));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         issue_valid  = vecs[i].iv;
         issue_opcode = vecs[i].op;
         issue_dest   = vecs[i].dest;
         alu_out      = vecs[i].alu;
         res_ready    = vecs[i].rr;
         rd_addr      = vecs[i].ra;
         #1 check($sformatf("vec%0d", i), snap(),
                  64'({vecs[i].rdy, vecs[i].cnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdest,
                       vecs[i].z, vecs[i].n, vecs[i].rd, vecs[i].err}));
      end

      // Illegal opcode: no write, no push, sticky error until reset
      @(negedge clk);
      issue_valid = 1'b1; issue_opcode = 4'b0011; issue_dest = 3'd5;
      res_ready = 1'b0; rd_addr = 3'd5;
      @(negedge clk);
      issue_valid = 1'b0; alu_out = 16'h7777;
      #1 check("illegal_not_yet", 64'(illegal_err), 64'(0));
      @(negedge clk);
      #1 check("illegal_set", 64'({illegal_err, fifo_count, res_valid, rd_data}),
               64'({1'b1, 3'd0, 1'b0, 16'h0000}));
      repeat (3) @(negedge clk);
      #1 check("illegal_sticky", 64'(illegal_err), 64'(1));
      rst_n = 1'b0;
      #1 check("illegal_cleared", 64'(illegal_err), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Reset the cycle after acceptance discards the pending result
      @(negedge clk);
      issue_valid = 1'b1; issue_opcode = 4'h8; issue_dest = 3'd2; rd_addr = 3'd2;
      @(negedge clk);
      issue_valid = 1'b0; alu_out = 16'hABCD;
      rst_n = 1'b0;
      #1 check("rst_async", 64'({issue_ready, fifo_count, res_valid}), 64'({1'b1, 3'd0, 1'b0}));
      @(negedge clk);
      rst_n = 1'b1;
      issue_valid = 1'b1; issue_opcode = 4'h9; issue_dest = 3'd6;
      @(negedge clk);
      issue_valid = 1'b0; alu_out = 16'h0042;
      #1 check("rst_discard", 64'({fifo_count, rd_data}), 64'({3'd0, 16'h0000}));
      @(negedge clk);
      rd_addr = 3'd6;
      #1 check("post_rst_issue", 64'({fifo_count, res_valid, res_data, res_dest, rd_data}),
               64'({3'd1, 1'b1, 16'h0042, 3'd6, 16'h0042}));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-002 Parameter: NREGS, default 8, architectural register count; index width RW = log2(NREGS) = 3.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 issue_valid  in  1  an op is being presented to the logical ALU this cycle.
REQ-006 issue_opcode  in  4  opcode presented to the ALU alongside issue_valid.
REQ-007 issue_dest  in  RW  destination register index of that op.
REQ-008 issue_ready  out  1  this block can absorb the op's result; the upstream stage issues only when high.
REQ-009 alu_out  in  16 signed  registered ALU result, valid exactly one cycle after an accepted issue.
REQ-010 rd_addr  in  RW  register file read address.
REQ-011 rd_data  out  16  combinational read of regs[rd_addr].
REQ-012 res_valid  out  1  FIFO head holds a result.
REQ-013 res_ready  in  1  consumer accepts the head.
REQ-014 res_data / res_dest  out  16 / RW  head result value and destination.
REQ-015 res_zero / res_neg  out  1 / 1  head flags: value == 0; value bit 15.
REQ-016 fifo_count  out  log2(DEPTH)+1  entries held.
REQ-017 illegal_err  out  1  sticky: an opcode outside 4'b1000..4'b1101 was accepted.

Function
REQ-018 Issue accepted on a cycle where issue_valid && issue_ready.
REQ-019 issue_ready SHALL equal (fifo_count + pend_valid) < DEPTH, so every accepted op has a guaranteed FIFO slot; it does not depend on issue_valid.
REQ-020 On acceptance, stage register captures pend_valid=1, pend_dest=issue_dest, pend_legal=(opcode in 1000..1101); with no acceptance pend_valid=0 next cycle.
REQ-021 Cycle after acceptance (pend_valid=1, pend_legal=1): regs[pend_dest] <= alu_out and FIFO pushes {alu_out, pend_dest, alu_out==0, alu_out[15]}.
REQ-022 pend_valid=1 with pend_legal=0: no register write, no FIFO push, illegal_err <= 1 (held until reset).
REQ-023 Accept-to-regfile latency 2 edges; accept-to-res_valid 2 edges when FIFO was empty; back-to-back issue sustains one result per cycle.
REQ-024 FIFO pop on res_valid && res_ready; push and pop in the same cycle leave fifo_count unchanged, including at full.
REQ-025 Pop with FIFO empty ignored; overflow impossible by REQ-019 and SHALL be asserted never to occur.
REQ-026 Read/write pointers wrap modulo DEPTH; res_* outputs are 0 when res_valid=0.
REQ-027 rd_data returns the pre-write value when rd_addr equals the register written in the same cycle (no bypass).
REQ-028 Two results to the same dest: later write wins in regs; both appear in FIFO in issue order.

Reset
REQ-029 rst_n low asynchronously clears: all regs to 0, FIFO pointers and fifo_count to 0, pend_valid 0, illegal_err 0; hence res_valid 0, res_* 0, issue_ready 1.
REQ-030 An op accepted before reset whose result cycle falls during or after reset is discarded (no write, no push).
REQ-031 Deassertion needs no idle cycles; issue may be accepted on the first edge after release.

Verification
REQ-032 Issue AND (1000) dest 3, alu_out 16'h00F0 next cycle -> regs[3]=00F0 after 2 edges; res_valid=1, res_data=00F0, res_dest=3, zero=0, neg=0.
REQ-033 res_ready=0, back-to-back issues -> issue_ready drops when count+pend reaches 4; exactly 4 results held, none lost; drain yields issue order.
REQ-034 FIFO full, res_ready=1 and one issue pending -> count stays 4, wrap across pointer boundary preserves order and flags (alu_out 16'h8000 -> neg=1; 0 -> zero=1).
REQ-035 Issue opcode 4'b0011 dest 5 -> regs[5] unchanged, no push, illegal_err=1 until rst_n pulses low.
REQ-036 Assert rst_n low the cycle after acceptance -> no write, fifo_count=0, res_valid=0, issue_ready=1 immediately (asynchronous).
